// File: rtl/seq_muldiv_pkg.sv
// Shared encodings and constants for the sequential multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_muldiv_pkg;

    // Operation select, as presented on the op port
    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,   // low half of product
        OP_MULH = 2'b01,   // high half of product
        OP_DIVU = 2'b10,   // unsigned quotient
        OP_REMU = 2'b11    // unsigned remainder
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // One iteration per operand bit
    localparam int ITER = 16;

    // Quotient returned when dividing by zero
    localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

    // DIVU and REMU share the divider datapath
    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/seq_muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rem_i    partial remainder from the previous iteration (always < divisor)
//        bit_i    next dividend bit, MSB first
//        divisor_i divisor
//        rem_o    updated partial remainder
//        q_o      quotient bit produced by this iteration
module div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    // The working remainder needs W+1 bits: after the shift it can exceed
    // the divisor by up to a factor of two.
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        // Non-negative difference: keep it, quotient bit is 1.
        q_o     = ~diff[W];
        // Either result is below the divisor, so the top bit is always zero.
        rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/seq_muldiv.sv
// Multi-cycle unsigned MUL/MULH/DIVU/REMU feeding the register file write port.
// Latency: start at edge N -> done N+16..N+17; zero divisor -> done N+1..N+2.
// Backpressure: none; start is only sampled in IDLE, callers wait for busy=0.
// Ports: clk/rst         clock, synchronous active-high reset
//        start/op/a/b/dst request, operation, operands (rd1, rd2), destination
//        busy/done/dz     status, one-cycle completion pulse, divide-by-zero
//        result/wa_out/we_out  register file wd/wa/we
module seq_muldiv
    import seq_muldiv_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [AW-1:0] dst,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic [AW-1:0] wa_out,
    output logic          we_out,
    output logic          dz
);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    dvd_q, dvd_d;     // dividend in, quotient shifts in behind it
    logic [W-1:0]    b_q, b_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [2*W-1:0]  prod_q, prod_d;   // {accumulator, multiplier}
    logic [W-1:0]    rem_q, rem_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    result_q, result_d;
    logic [AW-1:0]   wa_q, wa_d;

    // Shift-add multiply step: conditionally add the multiplicand into the
    // upper half, then shift the whole product right by one.
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  prod_nxt;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, b_q} : '0);
        prod_nxt = {mul_sum, prod_q[W-1:1]};
    end

    logic [W-1:0] step_rem;
    logic         step_q;
    logic [W-1:0] quot_nxt;

    div_step #(.W(W)) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[W-1]),
        .divisor_i (b_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quot_nxt = {dvd_q[W-2:0], step_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dvd_d    = dvd_q;
        b_d      = b_q;
        dst_d    = dst_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        result_d = result_q;
        wa_d     = wa_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    dvd_d   = a;
                    b_d     = b;
                    dst_d   = dst;
                    prod_d  = {{W{1'b0}}, a};
                    rem_d   = '0;
                    cnt_d   = '0;
                    dz_d    = is_div(op) && (b == '0);
                end
            end
            RUN: begin
                if (dz_q) begin
                    // Zero divisor: skip the iterations, one RUN cycle only.
                    state_d  = DONE;
                    wa_d     = dst_q;
                    result_d = (op_q == OP_DIVU) ? W'(DIV0_QUOT) : dvd_q;
                end else begin
                    prod_d = prod_nxt;
                    rem_d  = step_rem;
                    dvd_d  = quot_nxt;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'(ITER - 1)) begin
                        state_d = DONE;
                        wa_d    = dst_q;
                        unique case (op_q)
                            OP_MUL:  result_d = prod_nxt[W-1:0];
                            OP_MULH: result_d = prod_nxt[2*W-1:W];
                            OP_DIVU: result_d = quot_nxt;
                            default: result_d = step_rem;
                        endcase
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            dvd_q    <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
            result_q <= '0;
            wa_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dvd_q    <= dvd_d;
            b_q      <= b_d;
            dst_q    <= dst_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            wa_q     <= wa_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    // Register 0 is reloaded with pc every cycle; never write it.
    assign we_out = done && (dst_q != '0);
    assign dz     = done && dz_q;
    assign result = result_q;
    assign wa_out = wa_q;

endmodule

// File: tb/tb_seq_muldiv.sv
module tb_seq_muldiv;
    import seq_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [2:0]  dst;
    logic        busy, done, we_out, dz;
    logic [15:0] result;
    logic [2:0]  wa_out;

    seq_muldiv #(.W(16), .AW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .dst    (dst),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wa_out (wa_out),
        .we_out (we_out),
        .dz     (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [2:0]  wa;
        logic        we;
        logic        dz;
        int          lat;   // negedges after the start edge until done is seen
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                   input logic [2:0] d);
        exp_t        e;
        logic [31:0] p;
        p     = {16'h0, x} * {16'h0, y};
        e.dz  = o[1] && (y == 16'h0);
        case (o)
            2'b00:   e.res = p[15:0];
            2'b01:   e.res = p[31:16];
            2'b10:   e.res = e.dz ? 16'hFFFF : x / y;
            default: e.res = e.dz ? x : x % y;
        endcase
        e.wa  = d;
        e.we  = (d != 3'd0);
        e.lat = e.dz ? 2 : 17;
        return e;
    endfunction

    // Issue one operation, optionally pulse start again at edge N+pulse_at,
    // then wait for done and compare against the scoreboard head.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [2:0] d, input int pulse_at);
        exp_t e;
        int   k;
        logic seen;
        logic busy_ok;
        sb.push_back(model(o, x, y, d));
        @(negedge clk);
        op = o; a = x; b = y; dst = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~x; b = 16'h5A5A; dst = ~d;
        seen = 1'b0; busy_ok = 1'b1;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (pulse_at != 0 && k == pulse_at) begin
                start = 1'b1; op = OP_MUL; a = 16'h00FF; b = 16'h0101;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, " latency"}, 32'(k), 32'(e.lat));
            chk({tag, " busy_run"}, 32'(busy_ok), 32'd1);
            chk({tag, " busy_done"}, 32'(busy), 32'd1);
            chk({tag, " result"}, 32'(result), 32'(e.res));
            chk({tag, " wa_out"}, 32'(wa_out), 32'(e.wa));
            chk({tag, " we_out"}, 32'(we_out), 32'(e.we));
            chk({tag, " dz"}, 32'(dz), 32'(e.dz));
            @(negedge clk);
            chk({tag, " done_pulse"}, 32'(done), 32'd0);
            chk({tag, " we_after"}, 32'(we_out), 32'd0);
            chk({tag, " idle_after"}, 32'(busy), 32'd0);
            chk({tag, " result_hold"}, 32'(result), 32'(e.res));
        end
    endtask

    initial begin
        int  k;
        logic saw_done;

        // Reset, with start held high to show reset wins
        rst = 1'b1; start = 1'b1; op = OP_MUL; a = 16'd1; b = 16'd1; dst = 3'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset we_out", 32'(we_out), 32'd0);
        chk("reset dz", 32'(dz), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset wa_out", 32'(wa_out), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        do_op("mul_3x5",      OP_MUL,  16'd3,      16'd5,      3'd3, 0);
        do_op("mulh_ffff",    OP_MULH, 16'hFFFF,   16'hFFFF,   3'd5, 0);
        do_op("mul_ffff",     OP_MUL,  16'hFFFF,   16'hFFFF,   3'd1, 0);
        do_op("divu_100_7",   OP_DIVU, 16'd100,    16'd7,      3'd2, 0);
        do_op("remu_100_7",   OP_REMU, 16'd100,    16'd7,      3'd2, 0);
        do_op("divu_by0",     OP_DIVU, 16'h1234,   16'h0000,   3'd4, 0);
        do_op("remu_by0",     OP_REMU, 16'h1234,   16'h0000,   3'd4, 0);
        do_op("mul_dst0",     OP_MUL,  16'd2,      16'd2,      3'd0, 0);
        do_op("mul_ignore",   OP_MUL,  16'd3,      16'd7,      3'd6, 4);
        do_op("divu_ffff_1",  OP_DIVU, 16'hFFFF,   16'h0001,   3'd7, 0);
        do_op("remu_abcd",    OP_REMU, 16'hABCD,   16'h0100,   3'd3, 0);
        do_op("divu_small",   OP_DIVU, 16'd5,      16'd9,      3'd1, 0);
        do_op("mulh_mixed",   OP_MULH, 16'h8001,   16'h0003,   3'd2, 0);

        // Result holds while idle
        repeat (3) @(negedge clk);
        chk("hold result", 32'(result), 32'h0001);
        chk("hold wa_out", 32'(wa_out), 32'd2);

        // Reset mid-operation: sampled at edge N+8
        @(negedge clk);
        op = OP_MUL; a = 16'd9; b = 16'd9; dst = 3'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (k == 8) rst = 1'b1;
        end
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort we_out", 32'(we_out), 32'd0);
        rst = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || we_out) saw_done = 1'b1;
        end
        chk("abort no_done", 32'(saw_done), 32'd0);

        // Unit recovers after an abort
        do_op("mul_after_rst", OP_MUL, 16'd4, 16'd4, 3'd1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
